// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge (gen2).
//   bridge_state_e : bridge FSM states
//   HTRANS_*       : AHB transfer-type encodings
//   HRESP_*        : AHB response encodings
//   sel_w()        : width of the APB slave-index field for a given slave count
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WWAIT,
    SETUP,
    ACCESS,
    RESP,
    ERR1,
    ERR2
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // A single slave still needs a 1-bit index field.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Combinational APB slave decoder.
//   idx      : slave-index field taken from the AHB address
//   sel      : one-hot select, all zero when idx is out of range
//   in_range : idx addresses an existing slave
module apb_slave_decoder
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_W      = sel_w(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  in_range
);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (32'(idx) == i);
    end
    in_range = |sel;
  end

endmodule

// File: rtl/ahb_apb_bridge_gen2.sv
// AHB-to-APB3 bridge, one AHB slave port fanned out to NUM_SLAVES APB slaves,
// one transfer outstanding at a time.
//   AHB side : Hclk, Hresetn (async, active low), Hwrite, Hreadyin, Htrans,
//              Haddr, Hwdata -> Hrdata (registered), Hreadyout, Hresp
//   APB side : Paddr, Pwdata, Pwrite, Penable, Pselx (one-hot)
//              <- Prdata (slave i at [i*DATA_W +: DATA_W]), Pready, Pslverr
// Slave index = Haddr[SLV_SHIFT +: SEL_W]; higher address bits are ignored.
// Optional feature macro: AHB_APB_PSLVERR_EN maps PSLVERR and out-of-range
// accesses to a two-cycle AHB ERROR response. Without it Hresp is always OKAY.
module ahb_apb_bridge_gen2
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SLV_SHIFT  = 12
) (
  input  logic                         Hclk,
  input  logic                         Hresetn,
  input  logic                         Hwrite,
  input  logic                         Hreadyin,
  input  logic [1:0]                   Htrans,
  input  logic [ADDR_W-1:0]            Haddr,
  input  logic [DATA_W-1:0]            Hwdata,
  output logic [DATA_W-1:0]            Hrdata,
  output logic                         Hreadyout,
  output logic [1:0]                   Hresp,
  output logic [ADDR_W-1:0]            Paddr,
  output logic [DATA_W-1:0]            Pwdata,
  output logic                         Pwrite,
  output logic                         Penable,
  output logic [NUM_SLAVES-1:0]        Pselx,
  input  logic [NUM_SLAVES*DATA_W-1:0] Prdata,
  input  logic [NUM_SLAVES-1:0]        Pready,
  input  logic [NUM_SLAVES-1:0]        Pslverr
);

  localparam int unsigned SEL_W = sel_w(NUM_SLAVES);

  // Where a transfer that cannot complete normally on APB ends up.
`ifdef AHB_APB_PSLVERR_EN
  localparam bridge_state_e REJECT_ST = ERR1;
`else
  localparam bridge_state_e REJECT_ST = RESP;
`endif

  bridge_state_e           state_q, state_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_W-1:0]       hrdata_q, hrdata_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    in_range_q, in_range_d;

  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_in_range;
  logic                    hready_out;
  logic                    valid_req;
  logic                    pready_sel;
  logic [DATA_W-1:0]       prdata_sel;

  apb_slave_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_dec (
    .idx      (Haddr[SLV_SHIFT +: SEL_W]),
    .sel      (dec_sel),
    .in_range (dec_in_range)
  );

  // Only the selected slave's response is looked at; the registered one-hot
  // select doubles as the mux control.
  always_comb begin
    prdata_sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      prdata_sel = prdata_sel | (Prdata[i*DATA_W +: DATA_W] & {DATA_W{sel_q[i]}});
    end
  end

  assign pready_sel = |(Pready & sel_q);

`ifdef AHB_APB_PSLVERR_EN
  logic pslverr_sel;
  assign pslverr_sel = |(Pslverr & sel_q);
`else
  logic unused_pslverr;
  assign unused_pslverr = ^Pslverr;
`endif

  assign hready_out = (state_q == IDLE) || (state_q == RESP) || (state_q == ERR2);
  assign valid_req  = hready_out && Hreadyin &&
                      ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    hrdata_d   = hrdata_q;
    sel_d      = sel_q;
    in_range_d = in_range_q;

    case (state_q)
      IDLE, RESP, ERR2: begin
        if (valid_req) begin
          paddr_d    = Haddr;
          pwrite_d   = Hwrite;
          sel_d      = dec_sel;
          in_range_d = dec_in_range;
          if (Hwrite) begin
            state_d = WWAIT;
          end else if (dec_in_range) begin
            state_d = SETUP;
          end else begin
            // Read of a missing slave: no APB cycle, zero data.
            state_d  = REJECT_ST;
            hrdata_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WWAIT: begin
        pwdata_d = Hwdata;
        state_d  = in_range_q ? SETUP : REJECT_ST;
      end

      SETUP: state_d = ACCESS;

      ACCESS: begin
        if (pready_sel) begin
`ifdef AHB_APB_PSLVERR_EN
          if (pslverr_sel) begin
            state_d = ERR1;
            if (!pwrite_q) hrdata_d = '0;
          end else begin
            state_d = RESP;
            if (!pwrite_q) hrdata_d = prdata_sel;
          end
`else
          state_d = RESP;
          if (!pwrite_q) hrdata_d = prdata_sel;
`endif
        end
      end

`ifdef AHB_APB_PSLVERR_EN
      ERR1: state_d = ERR2;
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q    <= IDLE;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      hrdata_q   <= '0;
      sel_q      <= '0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      hrdata_q   <= hrdata_d;
      sel_q      <= sel_d;
      in_range_q <= in_range_d;
    end
  end

  assign Hrdata    = hrdata_q;
  assign Hreadyout = hready_out;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Pwrite    = pwrite_q;
  assign Penable   = (state_q == ACCESS);
  assign Pselx     = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;

`ifdef AHB_APB_PSLVERR_EN
  assign Hresp = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign Hresp = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// Self-checking bench for ahb_apb_bridge_gen2: a 4-slave bridge for the main
// scenarios and a 3-slave bridge for the out-of-range case.
module tb_ahb_apb_bridge_gen2;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
`ifdef AHB_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           Hclk = 1'b0;
  logic           Hresetn;
  logic           Hwrite, Hreadyin;
  logic [1:0]     Htrans;
  logic [AW-1:0]  Haddr;
  logic [DW-1:0]  Hwdata, Hrdata;
  logic           Hreadyout;
  logic [1:0]     Hresp;
  logic [AW-1:0]  Paddr;
  logic [DW-1:0]  Pwdata;
  logic           Pwrite, Penable;
  logic [NS-1:0]  Pselx, Pready, Pslverr;
  logic [NS*DW-1:0] Prdata;

  // 3-slave instance
  logic           hwrite3;
  logic [1:0]     htrans3;
  logic [AW-1:0]  haddr3;
  logic [DW-1:0]  hrdata3, pwdata3;
  logic           hreadyout3, pwrite3, penable3;
  logic [1:0]     hresp3;
  logic [AW-1:0]  paddr3;
  logic [2:0]     pselx3, pready3, pslverr3;
  logic [3*DW-1:0] prdata3;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Slave model: selected slave holds PREADY low for cur_waits ACCESS cycles;
  // non-selected slaves drive the opposite values so they must be ignored.
  int unsigned   cur_slave = 0;
  int unsigned   cur_waits = 0;
  bit            cur_err   = 1'b0;
  int unsigned   acc_cnt;
  logic [DW-1:0] slv_data [NS];

  // Reference state: what Hrdata should currently hold.
  logic [DW-1:0] model_hrdata = '0;
  logic [AW-1:0] model_paddr  = '0;

  always #5 Hclk = ~Hclk;

  ahb_apb_bridge_gen2 #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SLV_SHIFT(12)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Hrdata(Hrdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  ahb_apb_bridge_gen2 #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(3), .SLV_SHIFT(12)) dut3 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(hwrite3), .Hreadyin(Hreadyin), .Htrans(htrans3),
    .Haddr(haddr3), .Hwdata(Hwdata), .Hrdata(hrdata3), .Hreadyout(hreadyout3), .Hresp(hresp3),
    .Paddr(paddr3), .Pwdata(pwdata3), .Pwrite(pwrite3), .Penable(penable3), .Pselx(pselx3),
    .Prdata(prdata3), .Pready(pready3), .Pslverr(pslverr3)
  );

  always @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) acc_cnt <= 0;
    else if (Penable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      Pready[i]  = (i == int'(cur_slave)) ? (acc_cnt >= cur_waits) : (acc_cnt < cur_waits);
      Pslverr[i] = (i == int'(cur_slave)) ? cur_err : !cur_err;
      Prdata[i*DW +: DW] = slv_data[i];
    end
  end

  task automatic drive_addr(input logic [AW-1:0] a, input logic w);
    Haddr = a; Hwrite = w; Htrans = HT_NONSEQ; Hreadyin = 1'b1; Hwdata = $urandom;
  endtask

  // Runs one data phase (address phase already driven). Optionally issues the
  // next address phase in the final (ready) cycle.
  task automatic data_phase(
    input  logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
    input  int unsigned waits, input bit err, input logic [DW-1:0] rdat,
    input  bit nxt, input logic [AW-1:0] naddr, input logic nwr,
    output int unsigned len, output int unsigned pen, output logic [NS-1:0] psel_or,
    output logic [NS-1:0] first_psel, output logic first_pen, output bit apb_ok,
    output logic [1:0] hresp_prev);
    int unsigned slv;
    slv = int'((addr >> 12) & 32'h3);
    len = 0; pen = 0; psel_or = '0; apb_ok = 1'b1; hresp_prev = 2'b00;
    @(negedge Hclk);
    Htrans = HT_IDLE; Hwdata = wdata;
    cur_slave = slv; cur_waits = waits; cur_err = err;
    for (int i = 0; i < NS; i++) slv_data[i] = $urandom;
    slv_data[slv] = rdat;
    first_psel = Pselx; first_pen = Penable;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin
        @(negedge Hclk);
        Hwdata = $urandom;
      end
      len++;
      psel_or = psel_or | Pselx;
      if (Pselx != '0 && (Paddr !== addr || Pwrite !== wr)) apb_ok = 1'b0;
      if (Penable === 1'b1) begin
        pen++;
        if (wr && Pwdata !== wdata) apb_ok = 1'b0;
      end
      if (Hreadyout === 1'b1) break;
      hresp_prev = Hresp;
    end
    if (Hreadyout !== 1'b1) len = 999;
    if (nxt) begin
      Htrans = HT_NONSEQ; Haddr = naddr; Hwrite = nwr; Hreadyin = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge Hclk);
    n_checks++;
    if (Hreadyout !== 1'b1 || Hresp !== 2'b00 || Penable !== 1'b0 || Pselx !== '0)
      $display("FAIL reset_ctrl: rdy=%b resp=%b pen=%b psel=%b, want 1 00 0 0000",
               Hreadyout, Hresp, Penable, Pselx);
    else n_pass++;
    n_checks++;
    if (Hrdata !== '0 || Paddr !== '0 || Pwdata !== '0 || Pwrite !== 1'b0)
      $display("FAIL reset_data: hrdata=%h paddr=%h pwdata=%h pwrite=%b, want zeros",
               Hrdata, Paddr, Pwdata, Pwrite);
    else n_pass++;
    Hresetn = 1'b1;
  endtask

  task automatic test_read_zero_wait();
    int unsigned len, pen; logic [NS-1:0] ps, fps; logic fpe; bit ok; logic [1:0] hp;
    @(negedge Hclk); drive_addr(32'h0000_2010, 1'b0);
    data_phase(32'h0000_2010, 1'b0, '0, 0, 1'b0, 32'hCAFE_0001, 1'b0, '0, 1'b0,
               len, pen, ps, fps, fpe, ok, hp);
    model_hrdata = 32'hCAFE_0001; model_paddr = 32'h0000_2010;
    n_checks++; if (len !== 3) $display("FAIL rd_latency: got %0d want 3", len); else n_pass++;
    n_checks++; if (Hrdata !== model_hrdata) $display("FAIL rd_data: got %h want %h", Hrdata, model_hrdata); else n_pass++;
    n_checks++; if (ps !== 4'b0100 || pen !== 1) $display("FAIL rd_apb: psel=%b pen=%0d want 0100 1", ps, pen); else n_pass++;
    n_checks++; if (!ok || Hresp !== 2'b00) $display("FAIL rd_bus: apb_ok=%0d resp=%b want 1 00", ok, Hresp); else n_pass++;
  endtask

  task automatic test_write_waits();
    int unsigned len, pen; logic [NS-1:0] ps, fps; logic fpe; bit ok; logic [1:0] hp;
    @(negedge Hclk); drive_addr(32'h0000_1004, 1'b1);
    data_phase(32'h0000_1004, 1'b1, 32'h1234_5678, 2, 1'b0, $urandom, 1'b0, '0, 1'b0,
               len, pen, ps, fps, fpe, ok, hp);
    model_paddr = 32'h0000_1004;
    n_checks++; if (len - 1 !== 5) $display("FAIL wr_wait_low: got %0d want 5", len - 1); else n_pass++;
    n_checks++; if (!ok || pen !== 3) $display("FAIL wr_apb_hold: apb_ok=%0d pen=%0d want 1 3", ok, pen); else n_pass++;
    n_checks++; if (ps !== 4'b0010 || Pwdata !== 32'h1234_5678) $display("FAIL wr_sel_data: psel=%b pwdata=%h want 0010 12345678", ps, Pwdata); else n_pass++;
    n_checks++; if (Hrdata !== model_hrdata) $display("FAIL wr_hrdata_kept: got %h want %h", Hrdata, model_hrdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned len, pen; logic [NS-1:0] ps, fps; logic fpe; bit ok; logic [1:0] hp;
    logic [DW-1:0] r;
    r = $urandom;
    @(negedge Hclk); drive_addr(32'h0000_0000, 1'b1);
    data_phase(32'h0000_0000, 1'b1, $urandom, 0, 1'b0, $urandom, 1'b1, 32'h0000_3000, 1'b0,
               len, pen, ps, fps, fpe, ok, hp);
    n_checks++; if (len !== 4 || !ok) $display("FAIL b2b_wr: len=%0d apb_ok=%0d want 4 1", len, ok); else n_pass++;
    data_phase(32'h0000_3000, 1'b0, '0, 0, 1'b0, r, 1'b0, '0, 1'b0,
               len, pen, ps, fps, fpe, ok, hp);
    model_hrdata = r; model_paddr = 32'h0000_3000;
    n_checks++; if (fps !== 4'b1000 || fpe !== 1'b0) $display("FAIL b2b_setup: psel=%b pen=%b want 1000 0", fps, fpe); else n_pass++;
    n_checks++; if (len !== 3 || Hrdata !== r) $display("FAIL b2b_rd: len=%0d data=%h want 3 %h", len, Hrdata, r); else n_pass++;
  endtask

  task automatic test_pslverr();
    int unsigned len, pen; logic [NS-1:0] ps, fps; logic fpe; bit ok; logic [1:0] hp;
    logic [DW-1:0] r; logic [1:0] eresp;
    r = $urandom | 32'h1;
    eresp = {1'b0, ERR_EN};
    @(negedge Hclk); drive_addr(32'h0000_0040, 1'b0);
    data_phase(32'h0000_0040, 1'b0, '0, 1, 1'b1, r, 1'b0, '0, 1'b0,
               len, pen, ps, fps, fpe, ok, hp);
    model_hrdata = ERR_EN ? '0 : r; model_paddr = 32'h0000_0040;
    n_checks++; if (len !== 4 + int'(ERR_EN)) $display("FAIL err_latency: got %0d want %0d", len, 4 + int'(ERR_EN)); else n_pass++;
    n_checks++; if (Hresp !== eresp || hp !== eresp) $display("FAIL err_resp: last=%b prev=%b want %b", Hresp, hp, eresp); else n_pass++;
    n_checks++; if (Hrdata !== model_hrdata) $display("FAIL err_data: got %h want %h", Hrdata, model_hrdata); else n_pass++;
  endtask

  task automatic test_ignored();
    logic [1:0] tr [3];
    logic       rdy [3];
    tr[0] = HT_IDLE; rdy[0] = 1'b1;
    tr[1] = HT_BUSY; rdy[1] = 1'b1;
    tr[2] = HT_NONSEQ; rdy[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Hclk);
      Htrans = tr[k]; Hreadyin = rdy[k]; Haddr = $urandom; Hwrite = $urandom_range(0, 1);
      @(negedge Hclk);
      n_checks++;
      if (Hreadyout !== 1'b1 || Pselx !== '0 || Paddr !== model_paddr)
        $display("FAIL ignored_%0d: rdy=%b psel=%b paddr=%h want 1 0000 %h", k, Hreadyout, Pselx, Paddr, model_paddr);
      else n_pass++;
    end
    Htrans = HT_IDLE; Hreadyin = 1'b1;
  endtask

  task automatic test_out_of_range();
    int unsigned len; logic [2:0] ps;
    // First an in-range read so Hrdata holds something nonzero.
    @(negedge Hclk); haddr3 = 32'h0000_0008; hwrite3 = 1'b0; htrans3 = HT_NONSEQ;
    len = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Hclk); htrans3 = HT_IDLE; len++;
      if (hreadyout3 === 1'b1) break;
    end
    n_checks++; if (len !== 3 || hrdata3 !== prdata3[DW-1:0]) $display("FAIL oor_prior_rd: len=%0d data=%h want 3 %h", len, hrdata3, prdata3[DW-1:0]); else n_pass++;
    haddr3 = 32'h0000_3000; htrans3 = HT_NONSEQ;
    len = 0; ps = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Hclk); htrans3 = HT_IDLE; len++; ps = ps | pselx3;
      if (hreadyout3 === 1'b1) break;
    end
    n_checks++; if (len !== 1 + int'(ERR_EN) || ps !== 3'b000) $display("FAIL oor_apb: len=%0d psel=%b want %0d 000", len, ps, 1 + int'(ERR_EN)); else n_pass++;
    n_checks++; if (hrdata3 !== '0 || hresp3 !== {1'b0, ERR_EN}) $display("FAIL oor_resp: data=%h resp=%b want 0 %b", hrdata3, hresp3, {1'b0, ERR_EN}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge Hclk); drive_addr(32'h0000_1000, 1'b0);
    @(negedge Hclk); Htrans = HT_IDLE; cur_slave = 1; cur_waits = 20; cur_err = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (Penable === 1'b1) break;
      @(negedge Hclk);
    end
    n_checks++; if (Penable !== 1'b1 || Pselx !== 4'b0010) $display("FAIL rst_mid_access: pen=%b psel=%b want 1 0010", Penable, Pselx); else n_pass++;
    Hresetn = 1'b0;
    #1;
    n_checks++;
    if (Pselx !== '0 || Penable !== 1'b0 || Hreadyout !== 1'b1 || Hrdata !== '0)
      $display("FAIL rst_mid_now: psel=%b pen=%b rdy=%b data=%h want 0000 0 1 0", Pselx, Penable, Hreadyout, Hrdata);
    else n_pass++;
    @(negedge Hclk); Hresetn = 1'b1; cur_waits = 0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge Hclk);
      if (Hreadyout !== 1'b1 || Pselx !== '0 || Penable !== 1'b0 || Hresp !== 2'b00) ok = 1'b0;
    end
    n_checks++; if (!ok) $display("FAIL rst_mid_after: late activity, got ok=%0d want 1", ok); else n_pass++;
    model_hrdata = '0; model_paddr = '0;
  endtask

  task automatic test_random();
    localparam int unsigned N = 40;
    logic [AW-1:0] a [N]; logic w [N]; logic [DW-1:0] wd [N]; logic [DW-1:0] rd [N];
    int unsigned wt [N]; bit er [N]; bit ch [N];
    int unsigned len, pen, ni, slv, exp_len; logic [NS-1:0] ps, fps, exp_ps;
    logic fpe; bit ok, nxt, erx; logic [1:0] hp, exp_resp; logic [DW-1:0] exp_rd;
    for (int i = 0; i < int'(N); i++) begin
      a[i] = $urandom; w[i] = $urandom_range(0, 1); wd[i] = $urandom; rd[i] = $urandom;
      wt[i] = $urandom_range(0, 3); er[i] = ($urandom_range(0, 3) == 0); ch[i] = $urandom_range(0, 1);
    end
    @(negedge Hclk); drive_addr(a[0], w[0]);
    for (int i = 0; i < int'(N); i++) begin
      ni  = (i + 1 < int'(N)) ? i + 1 : i;
      nxt = ch[i] && (i + 1 < int'(N));
      data_phase(a[i], w[i], wd[i], wt[i], er[i], rd[i], nxt, a[ni], w[ni],
                 len, pen, ps, fps, fpe, ok, hp);
      slv      = int'((a[i] >> 12) & 32'h3);
      erx      = ERR_EN && er[i];
      exp_len  = (w[i] ? 4 : 3) + wt[i] + (erx ? 1 : 0);
      exp_ps   = '0; exp_ps[slv] = 1'b1;
      exp_resp = erx ? 2'b01 : 2'b00;
      exp_rd   = w[i] ? model_hrdata : (erx ? '0 : rd[i]);
      model_hrdata = exp_rd;
      n_checks++; if (len !== exp_len) $display("FAIL rnd%0d_len: got %0d want %0d", i, len, exp_len); else n_pass++;
      n_checks++; if (Hrdata !== exp_rd) $display("FAIL rnd%0d_data: got %h want %h", i, Hrdata, exp_rd); else n_pass++;
      n_checks++; if (Hresp !== exp_resp || hp !== exp_resp) $display("FAIL rnd%0d_resp: last=%b prev=%b want %b", i, Hresp, hp, exp_resp); else n_pass++;
      n_checks++; if (ps !== exp_ps || pen !== wt[i] + 1) $display("FAIL rnd%0d_apb: psel=%b pen=%0d want %b %0d", i, ps, pen, exp_ps, wt[i] + 1); else n_pass++;
      n_checks++; if (!ok) $display("FAIL rnd%0d_stable: addr/data held=%0d want 1", i, ok); else n_pass++;
      if (!nxt && i + 1 < int'(N)) begin
        repeat ($urandom_range(0, 2)) @(negedge Hclk);
        @(negedge Hclk); drive_addr(a[i + 1], w[i + 1]);
      end
    end
  endtask

  initial begin
    Hresetn = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = HT_IDLE; Haddr = '0; Hwdata = '0;
    hwrite3 = 1'b0; htrans3 = HT_IDLE; haddr3 = '0;
    pready3 = 3'b111; pslverr3 = 3'b000;
    prdata3 = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    for (int i = 0; i < NS; i++) slv_data[i] = '0;
    repeat (2) @(negedge Hclk);
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_back_to_back();
    test_pslverr();
    test_ignored();
    test_out_of_range();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge Hclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
